// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and debug-halt controller for a 5-stage core.
//
// Decides each cycle whether the front end advances, stalls or is flushed.
// Stalls cover load-use hazards and branches that depend on an in-flight
// result. Flushes cover taken branches and jumps. A debug halt drains the
// pipeline and then parks it.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   id_rs, id_rt      source registers of the ID instruction
//   id_uses_rt        ID instruction reads rt
//   id_branch/id_jump ID instruction class
//   branch_taken      branch outcome resolved in ID
//   ex_mem_read, ex_reg_write, ex_rd   EX-stage load flag, write flag, dest
//   mem_mem_read, mem_rd               MEM-stage load flag, dest
//   halt_req          debug halt request
//   pc_write, ifid_write, ifid_flush, idex_bubble   pipeline control (comb)
//   halted            registered, high exactly while in HALTED
//   state             current FSM state
//   stall_cnt, flush_cnt   saturating performance counters
//
// Configuration macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cnt/flush_cnt count stall/redirect cycles in RUN
//   undefined -> both ports tied to 0 and no counter flops exist
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal operation, hazards stall, redirects flush
// DRAIN | halt requested, IF/ID frozen while EX/MEM/WB empty (3 cycles)
// HALTED| pipeline parked until halt_req drops

module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_branch,
    input  logic        id_jump,
    input  logic        branch_taken,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd,
    input  logic        halt_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Last drain count value before HALTED: counts 0,1,2 over three cycles.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    logic [1:0] state_r;
    logic [1:0] state_nxt;
    logic [1:0] drain_cnt;
    logic [1:0] drain_nxt;
    logic       halted_r;

    logic match_ex;
    logic match_mem;
    logic hazard;
    logic redirect;

    // Register 0 is hard-wired, so it never creates a dependency.
    always_comb begin
        match_ex  = (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        match_mem = (mem_rd != 5'd0) &&
                    ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));
        hazard    = (ex_mem_read && match_ex) ||
                    (id_branch && ex_reg_write && match_ex) ||
                    (id_branch && mem_mem_read && match_mem);
        // A stalled branch must not redirect until its operands are ready.
        redirect  = !hazard && (id_jump || (id_branch && branch_taken));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            drain_cnt <= 2'd0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            drain_cnt <= drain_nxt;
            halted_r  <= (state_nxt == ST_HALTED);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        drain_nxt = drain_cnt;
        case (state_r)
            ST_RUN: begin
                // Halt waits until any stall or redirect has completed.
                if (halt_req && !hazard && !redirect) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = 2'd0;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_nxt = ST_RUN;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_nxt = drain_cnt + 2'd1;
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        if (rst) begin
            ifid_flush  = 1'b1;
        end else if (state_r == ST_RUN) begin
            if (hazard) begin
                idex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = redirect;
                idex_bubble = 1'b0;
            end
        end
    end

    assign state  = state_r;
    assign halted = halted_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if ((state_r == ST_RUN) && hazard && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if ((state_r == ST_RUN) && redirect && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock for all state.
REQ-002 SHALL have rst in 1, synchronous active-high reset.
REQ-003 SHALL have id_rs, id_rt in 5 each, source registers of the instruction in ID.
REQ-004 SHALL have id_uses_rt in 1, ID instruction reads rt.
REQ-005 SHALL have id_branch in 1 and id_jump in 1, ID instruction class.
REQ-006 SHALL have branch_taken in 1, branch outcome resolved in ID.
REQ-007 SHALL have ex_mem_read in 1, ex_reg_write in 1 and ex_rd in 5, EX-stage load flag, write flag and destination.
REQ-008 SHALL have mem_mem_read in 1 and mem_rd in 5, MEM-stage load flag and destination.
REQ-009 SHALL have halt_req in 1, debug request to stop the pipeline.
REQ-010 SHALL have these outputs:
- pc_write out 1;
- ifid_write out 1;
- ifid_flush out 1;
- idex_bubble out 1;
- halted out 1;
- state out 2;
- stall_cnt out 16;
- flush_cnt out 16.

Function
REQ-011 SHALL define match(r) = (r!=0) && (r==id_rs || (id_uses_rt && r==id_rt)); register 0 never causes a hazard.
REQ-012 SHALL define hazard H as the OR of three terms:
- ex_mem_read && match(ex_rd) (load-use);
- id_branch && ex_reg_write && match(ex_rd);
- id_branch && mem_mem_read && match(mem_rd).
REQ-013 SHALL define redirect R = !H && (id_jump || (id_branch && branch_taken)).
REQ-014 SHALL implement an FSM with three states: RUN=0, DRAIN=1, HALTED=2; the current state SHALL drive the state output.
REQ-015 SHALL drive outputs in RUN with H=1 as pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
REQ-016 SHALL drive outputs in RUN with R=1 as pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0.
REQ-017 SHALL drive outputs in RUN with neither H nor R as pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-018 SHALL make all four control outputs combinational from state and inputs, with zero-cycle latency.
REQ-019 SHALL move RUN to DRAIN on a clock edge with halt_req=1, H=0 and R=0.
REQ-020 SHALL defer the halt while H or R is asserted, so a stalled instruction or a redirect completes first.
REQ-021 SHALL in DRAIN and HALTED drive pc_write=0, ifid_write=0, idex_bubble=1 and ifid_flush=0, freezing IF/ID and emptying EX/MEM/WB.
REQ-022 SHALL hold a 2-bit drain counter that clears on entry to DRAIN.
REQ-023 SHALL move DRAIN to HALTED after exactly 3 cycles spent in DRAIN.
REQ-024 SHALL return DRAIN to RUN on the next edge if halt_req drops during DRAIN; the drain aborts and no instruction is lost.
REQ-025 SHALL move HALTED to RUN on an edge with halt_req=0.
REQ-026 SHALL on resume re-present the frozen IF/ID instruction to ID, with hazard evaluation resuming normally.
REQ-027 SHALL register halted, asserting it exactly while state==HALTED.
REQ-028 SHALL treat state encoding 3 as illegal and return to RUN on the next edge.

Reset
REQ-029 SHALL while rst=1 at a clock edge set state=RUN, the drain counter to 0, halted=0, stall_cnt=0 and flush_cnt=0.
REQ-030 SHALL while rst=1 force the combinational outputs to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, regardless of the other inputs.
REQ-031 SHALL apply reset asserted mid-DRAIN or in HALTED in the same cycle, with no residual drain count.

Configuration
REQ-032 SHALL gate the performance counters with macro HAZARD_PERF_CNT_EN.
REQ-033 SHALL with HAZARD_PERF_CNT_EN defined increment stall_cnt on each edge with state==RUN && H.
REQ-034 SHALL with HAZARD_PERF_CNT_EN defined increment flush_cnt on each edge with state==RUN && R.
REQ-035 SHALL saturate both counters at 0xFFFF with no wrap.
REQ-036 SHALL with HAZARD_PERF_CNT_EN undefined keep both ports present but tied to 0, with no counter flops.

Verification
REQ-037 SHALL cover load-use stall:
- Stimulus: ex_mem_read=1, ex_rd=8, id_rs=8 for 1 cycle.
- Response: pc_write=0, ifid_write=0, idex_bubble=1; with the macro, stall_cnt goes 0->1.
REQ-038 SHALL cover the zero-register case:
- Stimulus: ex_mem_read=1, ex_rd=0, id_rs=0.
- Response: no stall; pc_write=1.
REQ-039 SHALL cover branch dependency and redirect:
- Stimulus: id_branch=1, branch_taken=1, ex_reg_write=1, ex_rd=9, id_rt=9, id_uses_rt=1.
- Response: stall first (ifid_flush=0); after ex_rd changes to 10, ifid_flush=1 and pc_write=1.
REQ-040 SHALL cover halt and resume:
- Stimulus: halt_req=1 in RUN with no hazard.
- Response: state 1 for 3 cycles, then state=2 with halted=1; after halt_req=0, state=0 next edge with pc_write=1.
REQ-041 SHALL cover halt abort and halt deferral:
- Stimulus A: drop halt_req at the second DRAIN cycle. Response A: state=0 next edge, halted never 1.
- Stimulus B: halt_req with H=1. Response B: state stays 0 until H clears.
REQ-042 SHALL cover mid-drain reset and counter saturation:
- Stimulus A: rst=1 during DRAIN. Response A: state=0, ifid_flush=1, idex_bubble=1; counters 0 next edge.
- Stimulus B: with the macro, 65540 stall cycles. Response B: stall_cnt=0xFFFF.
